observer_sample_sequencer: RTL
==============================

Name: observer_sample_sequencer

Overview:
- Hardware Avalon-MM master that owns the 16-bit interval-timer slave and turns it into the observer's fixed-rate sample clock, with no CPU involvement.
- Sequences the timer through programming, start and stop.
- Acknowledges each timeout and issues a one-cycle sample tick to the observer datapath.
- Counts ticks and flags ticks the observer was still too busy to accept.

Parameters:
- DEFAULT_PERIOD, 50000: sample period in clk cycles, used on the first enable after reset.
- MIN_PERIOD, 2: smallest accepted period; smaller requests are clamped up to it.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = run the sample clock, 0 = stop it
- period_wr  in  1  one-cycle strobe; latch period_in as the new period
- period_in  in  32  requested period, in clk cycles
- tmr_address  out  3  timer register index (0 status, 1 control, 2 period_l, 3 period_h)
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt (level)
- obs_busy  in  1  observer still processing the previous sample
- clr_overrun  in  1  one-cycle strobe; clears overrun
- tick  out  1  one-cycle sample strobe
- tick_count  out  32  ticks issued since reset; wraps
- overrun  out  1  sticky: a tick was issued while obs_busy = 1
- running  out  1  timer programmed and counting

Behaviour:
- Reset values:
  - tmr_chipselect = 0, tmr_write_n = 1, tmr_address = 0, tmr_writedata = 0.
  - tick = 0, tick_count = 0, overrun = 0, running = 0.
  - State = IDLE; period register = DEFAULT_PERIOD; pending = 0.
- All master outputs are registered. Every bus access is a single-cycle write with no waitrequest; the block never issues reads.
- Load value written to the timer = period − 1. period_in < MIN_PERIOD is clamped to MIN_PERIOD.
- period_wr in any state latches the clamped period and sets pending.
- FSM states and transitions:
  - IDLE: if enable → WR_PL.
  - WR_PL: write address 2 with load[15:0] → WR_PH.
  - WR_PH: write address 3 with load[31:16]; clear pending → WR_CTRL.
  - WR_CTRL: write address 1 with 0x0007 (START, CONT, ITO) → RUN; running = 1 from the next cycle.
  - RUN: checks in priority order:
    - tmr_irq = 1 → ACK
    - enable = 0 → STOP
    - pending = 1 → WR_PL (the period write force-stops the timer, so the full sequence reruns and control is rewritten)
    - otherwise stay in RUN.
  - ACK: write address 0 (clear timeout); tick = 1 for this cycle; tick_count += 1; if obs_busy, set overrun → RUN. The timer's irq drops before RUN re-samples it, so one timeout yields exactly one tick.
  - STOP: write address 1 with 0x0008 (STOP); running = 0 → IDLE.
- Latency: a timeout irq rising in cycle N gives tick in cycle N+1.
- Simultaneous events:
  - irq together with enable falling or period_wr → ACK is served first; stop or reprogram follows from RUN.
  - clr_overrun and a setting event in the same cycle → overrun remains 1 (set wins).
- enable dropping during WR_* → the sequence completes into RUN, then RUN → STOP.
- An irq arriving while in WR_PL, WR_PH or WR_CTRL is cleared by the timer's force_reload path and is not ticked.
- tick_count wraps from 0xFFFF_FFFF to 0.
- Asynchronous reset mid-write returns everything to reset values immediately. The timer slave is reset by the same reset_n.

Decomposition:
- Shared package observer_timer_pkg holds:
  - timer register indices TMR_STATUS = 0, TMR_CONTROL = 1, TMR_PERIODL = 2, TMR_PERIODH = 3
  - control bit constants CTRL_ITO = 0x1, CTRL_CONT = 0x2, CTRL_START = 0x4, CTRL_STOP = 0x8
  - FSM state enum seq_state_t.
- One sub-module, avmm_write_port: registers address, writedata, chipselect and write_n from a one-cycle request.
- FSM, period logic and counters stay in the top level.

Test Plan:
- Reset, enable = 1, default period → bus writes addr 2 = 0xC34F, addr 3 = 0x0000, addr 1 = 0x0007 on consecutive cycles; with the real timer attached, ticks are 50000 cycles apart.
- period_wr with period_in = 10 while running → rewrite addr 2 = 0x0009, addr 3 = 0, addr 1 = 0x0007; following ticks are 10 cycles apart; tick_count continues without reset.
- period_in = 1 → clamped; addr 2 = 0x0001; ticks 2 cycles apart; no tick lost, one addr-0 write per tick.
- obs_busy held high across a tick → overrun = 1; clr_overrun pulsed on the same cycle as a later busy tick → overrun stays 1; clr_overrun alone → 0.
- enable 1→0 in the same cycle as irq → ACK write to addr 0 and tick, then addr 1 = 0x0008, running = 0, no further ticks.
- reset_n asserted during WR_PH → chipselect = 0 and tick_count = 0 immediately; after release with enable = 1, the full WR_PL/WR_PH/WR_CTRL sequence restarts.

Source files
------------

// File: rtl/observer_timer_pkg.sv
// -----------------------------------------------------------------------------
// observer_timer_pkg
// Shared definitions for the observer sample sequencer and its timer master:
//   - register indices of the 16-bit interval-timer slave
//   - control-register bit constants
//   - sequencer FSM state type
//   - period clamp helper
// No ports (package).
// -----------------------------------------------------------------------------
package observer_timer_pkg;

    // Interval-timer register map (word indices on the Avalon-MM address bus)
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    // Control register bits
    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    // Control word that starts continuous counting with the timeout irq enabled
    localparam logic [15:0] CTRL_RUN_WORD = CTRL_START | CTRL_CONT | CTRL_ITO;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_ACK,
        ST_STOP
    } seq_state_t;

    // Periods below the minimum are raised to it
    function automatic logic [31:0] clamp_period(input logic [31:0] req,
                                                 input logic [31:0] min_p);
        return (req < min_p) ? min_p : req;
    endfunction

endpackage

// File: rtl/avmm_write_port.sv
// -----------------------------------------------------------------------------
// avmm_write_port
// Registers a one-cycle write request onto the Avalon-MM master signals, so
// every bus output comes straight from a flop. A request in cycle N becomes a
// single-cycle write in cycle N+1 (slave has no waitrequest).
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   req_i           one-cycle write request
//   addr_i, data_i  address / write data belonging to the request
//   address_o       registered address
//   chipselect_o    registered select (high for exactly one cycle per request)
//   write_n_o       registered active-low write strobe
//   writedata_o     registered write data
// -----------------------------------------------------------------------------
module avmm_write_port (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] data_i,
    output logic [2:0]  address_o,
    output logic        chipselect_o,
    output logic        write_n_o,
    output logic [15:0] writedata_o
);

    logic [2:0]  address_q;
    logic        chipselect_q;
    logic        write_n_q;
    logic [15:0] writedata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= 3'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= 16'h0000;
        end else begin
            chipselect_q <= req_i;
            write_n_q    <= ~req_i;
            // Address/data only move on a request; they are don't-care otherwise
            if (req_i) begin
                address_q   <= addr_i;
                writedata_q <= data_i;
            end
        end
    end

    assign address_o    = address_q;
    assign chipselect_o = chipselect_q;
    assign write_n_o    = write_n_q;
    assign writedata_o  = writedata_q;

endmodule

// File: rtl/observer_sample_sequencer.sv
// -----------------------------------------------------------------------------
// observer_sample_sequencer
// Avalon-MM master that owns the interval timer and turns its timeouts into a
// fixed-rate one-cycle sample tick for the observer datapath.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              level: run (1) / stop (0) the sample clock
//   period_wr/period_in strobe + value: new period in clk cycles
//   tmr_*               timer master (registered single-cycle writes only)
//   tmr_irq             timer timeout interrupt (level)
//   obs_busy            observer still working on the previous sample
//   clr_overrun         strobe: clear the sticky overrun flag
//   tick                one-cycle sample strobe
//   tick_count          ticks issued since reset (wraps)
//   overrun             sticky: a tick was issued while obs_busy was high
//   running             timer programmed and counting
// -----------------------------------------------------------------------------
module observer_sample_sequencer
    import observer_timer_pkg::*;
#(
    parameter int unsigned DEFAULT_PERIOD = 50000,
    parameter int unsigned MIN_PERIOD     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        period_wr,
    input  logic [31:0] period_in,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    input  logic        obs_busy,
    input  logic        clr_overrun,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic        overrun,
    output logic        running
);

    seq_state_t  state_q, state_d;
    logic [31:0] period_q;
    logic        pending_q;
    logic        tick_q;
    logic [31:0] tick_count_q;
    logic        overrun_q;
    logic        running_q;

    logic [31:0] load_value;
    logic        wr_req;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    assign load_value = period_q - 32'd1;

    // Next state plus the bus write that belongs to the state being entered.
    // The write port registers the request, so each write lands on the bus in
    // the same cycle the FSM sits in the corresponding state.
    always_comb begin
        state_d = state_q;
        wr_req  = 1'b0;
        wr_addr = TMR_STATUS;
        wr_data = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WR_PL;
                    wr_req  = 1'b1;
                    wr_addr = TMR_PERIODL;
                    wr_data = load_value[15:0];
                end
            end
            ST_WR_PL: begin
                state_d = ST_WR_PH;
                wr_req  = 1'b1;
                wr_addr = TMR_PERIODH;
                wr_data = load_value[31:16];
            end
            ST_WR_PH: begin
                state_d = ST_WR_CTRL;
                wr_req  = 1'b1;
                wr_addr = TMR_CONTROL;
                wr_data = CTRL_RUN_WORD;
            end
            ST_WR_CTRL: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A timeout is always served before stop/reprogram
                if (tmr_irq) begin
                    state_d = ST_ACK;
                    wr_req  = 1'b1;
                    wr_addr = TMR_STATUS;
                    wr_data = 16'h0000;
                end else if (!enable) begin
                    state_d = ST_STOP;
                    wr_req  = 1'b1;
                    wr_addr = TMR_CONTROL;
                    wr_data = CTRL_STOP;
                end else if (pending_q) begin
                    // Writing the period stops the timer, so rerun the whole sequence
                    state_d = ST_WR_PL;
                    wr_req  = 1'b1;
                    wr_addr = TMR_PERIODL;
                    wr_data = load_value[15:0];
                end
            end
            ST_ACK: begin
                state_d = ST_RUN;
            end
            ST_STOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            period_q     <= DEFAULT_PERIOD;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= 32'd0;
            overrun_q    <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (period_wr) begin
                period_q <= clamp_period(period_in, MIN_PERIOD);
            end

            // A period write racing the high-word write keeps pending set so
            // the sequence reruns with a consistent pair of halves.
            if (period_wr) begin
                pending_q <= 1'b1;
            end else if (state_q == ST_WR_PH) begin
                pending_q <= 1'b0;
            end

            tick_q <= (state_d == ST_ACK);
            if (state_d == ST_ACK) begin
                tick_count_q <= tick_count_q + 32'd1;
            end

            // Setting wins over a simultaneous clear
            if (tick_q && obs_busy) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end

            if (state_q == ST_WR_CTRL) begin
                running_q <= 1'b1;
            end else if (state_q == ST_STOP) begin
                running_q <= 1'b0;
            end
        end
    end

    avmm_write_port u_write_port (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (wr_req),
        .addr_i       (wr_addr),
        .data_i       (wr_data),
        .address_o    (tmr_address),
        .chipselect_o (tmr_chipselect),
        .write_n_o    (tmr_write_n),
        .writedata_o  (tmr_writedata)
    );

    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign overrun    = overrun_q;
    assign running    = running_q;

endmodule
